bs_tx_sequencer: RTL and testbench

- Sequences one backscatter reply through the FM0/Miller modulator. Generates the BLF half-symbol tick, modulator enable, violation and pilot flags, and the serial bit stream: pilot, preamble, payload, dummy '1'.
- Sits between the reply-assembly/memory logic, which supplies payload bits one at a time, and the modulator.
- Clears the modulator after each reply and on abort.

---
 rtl/bs_tx_sequencer_if.sv | 38 +++
 rtl/bs_tx_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_bs_tx_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_tx_sequencer_if.sv
// Bus bundle between the backscatter reply sequencer, the reply-assembly
// logic (start/config/payload fetch) and the FM0/Miller modulator.
//   master : reply-assembly side (drives i_*, observes o_*)
//   slave  : sequencer side (observes i_*, drives o_*)
interface bs_tx_sequencer_if #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned DIV_W = 8
);
    logic             i_start;
    logic             i_abort;
    logic [1:0]       i_m_dec;
    logic             i_trext;
    logic [DIV_W-1:0] i_blf_div;
    logic [LEN_W-1:0] i_tx_len;
    logic             i_tx_bit;

    logic             o_bit_rd;
    logic             o_en2blf_mod;
    logic             o_enable_mod;
    logic             o_data_ocu;
    logic             o_violate_mod;
    logic             o_mblf_mod;
    logic             o_clear_cu;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_abort, i_m_dec, i_trext, i_blf_div, i_tx_len, i_tx_bit,
        input  o_bit_rd, o_en2blf_mod, o_enable_mod, o_data_ocu, o_violate_mod,
               o_mblf_mod, o_clear_cu, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_m_dec, i_trext, i_blf_div, i_tx_len, i_tx_bit,
        output o_bit_rd, o_en2blf_mod, o_enable_mod, o_data_ocu, o_violate_mod,
               o_mblf_mod, o_clear_cu, o_busy, o_done
    );
endinterface

// File: rtl/bs_tx_sequencer.sv
// Backscatter reply sequencer: generates the BLF tick and walks one reply
// (pilot, preamble, payload, dummy '1', tail) through the modulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bs_tx_sequencer_if.slave -- start/abort/config and payload
//                fetch from reply assembly, tick/enable/data/flags/clear to
//                the modulator, busy/done status
// All outputs are registered. Slot changes happen on the edge that ends a
// slot-closing tick cycle, so data/flags are stable for the whole next slot.
module bs_tx_sequencer #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bs_tx_sequencer_if.slave bus
);
    localparam int unsigned TK_W = 4;
    // Preamble patterns, bit k = slot k
    localparam logic [7:0] FM0_PAT = 8'b0010_0101;  // 1,0,1,0,0,1
    localparam logic [7:0] MIL_PAT = 8'b0011_1010;  // 0,1,0,1,1,1

    typedef enum logic [2:0] {
        S_IDLE, S_PILOT, S_PREAMBLE, S_DATA, S_DUMMY, S_TAIL, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt, w_adv_state;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt, r_div, w_div_nxt, w_div_m1;
    logic [TK_W-1:0]  r_tk, w_tk_nxt, w_tpb_m1;
    logic [LEN_W-1:0] r_idx, w_idx_nxt, w_adv_idx, r_len, w_len_nxt;
    logic [LEN_W-1:0] w_pilot_last, w_pre_last;
    logic [1:0]       r_m, w_m_nxt;
    logic             r_trext, w_trext_nxt;
    logic             r_bit_rd, r_tick, r_en, r_data, r_viol, r_mblf, r_clear, r_busy, r_done;
    logic             w_bit_rd_nxt, w_tick_nxt, w_en_nxt, w_data_nxt, w_viol_nxt;
    logic             w_mblf_nxt, w_clear_nxt, w_busy_nxt, w_done_nxt;
    logic             w_in_slot, w_close, w_abort;
    logic [2:0]       w_slot;

    // {data, violate, mblf} for a slot that is about to begin
    function automatic logic [2:0] f_slot(input state_t st, input logic [LEN_W-1:0] idx,
                                          input logic [1:0] m, input logic trext);
        logic [LEN_W-1:0] pos;
        logic [2:0]       slot;
        slot = 3'b000;
        pos  = (m == 2'b00 && trext) ? idx - LEN_W'(12) : idx;
        case (st)
            S_PILOT:    slot = 3'b001;
            S_PREAMBLE: begin
                if (m != 2'b00)
                    slot = {MIL_PAT[pos[2:0]], 2'b00};
                else if (!(trext && idx < LEN_W'(12)))
                    slot = {FM0_PAT[pos[2:0]], pos == LEN_W'(4), 1'b0};
            end
            S_DUMMY, S_TAIL: slot = 3'b100;
            default:    slot = 3'b000;
        endcase
        return slot;
    endfunction

    always_comb begin
        case (r_m)
            2'b00:   w_tpb_m1 = TK_W'(1);
            2'b01:   w_tpb_m1 = TK_W'(3);
            2'b10:   w_tpb_m1 = TK_W'(7);
            default: w_tpb_m1 = TK_W'(15);
        endcase
    end

    assign w_div_m1     = r_div - DIV_W'(1);
    assign w_pilot_last = r_trext ? LEN_W'(15) : LEN_W'(3);
    assign w_pre_last   = (r_m == 2'b00 && r_trext) ? LEN_W'(17) : LEN_W'(5);
    assign w_in_slot    = (r_state == S_PILOT) || (r_state == S_PREAMBLE) ||
                          (r_state == S_DATA)  || (r_state == S_DUMMY);
    assign w_close      = r_tick && (r_tk == w_tpb_m1);
    assign w_abort      = (r_state != S_IDLE) && bus.i_abort;

    // Which slot follows the current one
    always_comb begin
        w_adv_state = r_state;
        w_adv_idx   = r_idx + LEN_W'(1);
        case (r_state)
            S_PILOT: if (r_idx == w_pilot_last) begin
                w_adv_state = S_PREAMBLE;
                w_adv_idx   = '0;
            end
            S_PREAMBLE: if (r_idx == w_pre_last) begin
                w_adv_state = (r_len == '0) ? S_DUMMY : S_DATA;
                w_adv_idx   = '0;
            end
            S_DATA: if (r_idx == r_len - LEN_W'(1)) begin
                w_adv_state = S_DUMMY;
                w_adv_idx   = '0;
            end
            S_DUMMY: begin
                w_adv_state = S_TAIL;
                w_adv_idx   = '0;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; abort wins over everything outside IDLE, start only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.i_start && !bus.i_abort)
                w_state_nxt = (bus.i_m_dec == 2'b00) ? S_PREAMBLE : S_PILOT;
            S_PILOT, S_PREAMBLE, S_DATA, S_DUMMY: if (w_close) w_state_nxt = w_adv_state;
            S_TAIL: if (r_tick && r_idx == LEN_W'(1)) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Next values of counters, latched config and outputs
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_tk_nxt     = r_tk;
        w_idx_nxt    = r_idx;
        w_m_nxt      = r_m;
        w_trext_nxt  = r_trext;
        w_div_nxt    = r_div;
        w_len_nxt    = r_len;
        w_en_nxt     = r_en;
        w_data_nxt   = r_data;
        w_viol_nxt   = r_viol;
        w_mblf_nxt   = r_mblf;
        w_busy_nxt   = r_busy;
        w_bit_rd_nxt = 1'b0;
        w_tick_nxt   = 1'b0;
        w_clear_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_slot       = 3'b000;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tk_nxt  = '0;
                w_idx_nxt = '0;
                if (bus.i_start && !bus.i_abort) begin
                    w_m_nxt     = bus.i_m_dec;
                    w_trext_nxt = bus.i_trext;
                    w_div_nxt   = (bus.i_blf_div < DIV_W'(2)) ? DIV_W'(2) : bus.i_blf_div;
                    w_len_nxt   = bus.i_tx_len;
                    w_busy_nxt  = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_slot      = f_slot(w_state_nxt, '0, bus.i_m_dec, bus.i_trext);
                    {w_data_nxt, w_viol_nxt, w_mblf_nxt} = w_slot;
                end
            end
            S_DONE: begin
                w_cnt_nxt  = '0;
                w_tk_nxt   = '0;
                w_idx_nxt  = '0;
                w_busy_nxt = 1'b0;
                w_en_nxt   = 1'b0;
                w_data_nxt = 1'b0;
                w_viol_nxt = 1'b0;
                w_mblf_nxt = 1'b0;
            end
            default: begin
                w_cnt_nxt = (r_cnt == w_div_m1) ? '0 : r_cnt + DIV_W'(1);
                if (r_state == S_TAIL) begin
                    // Two ticks let the modulator settle before done/clear
                    if (r_tick) begin
                        w_idx_nxt = r_idx + LEN_W'(1);
                        if (r_idx == LEN_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_clear_nxt = 1'b1;
                        end
                    end
                end else if (r_tick) begin
                    if (w_close) begin
                        w_tk_nxt  = '0;
                        w_idx_nxt = w_adv_idx;
                        w_slot    = f_slot(w_adv_state, w_adv_idx, r_m, r_trext);
                        {w_data_nxt, w_viol_nxt, w_mblf_nxt} = w_slot;
                        if (w_adv_state == S_DATA) w_data_nxt = bus.i_tx_bit;
                        if (w_adv_state == S_TAIL) w_en_nxt   = 1'b0;
                    end else begin
                        w_tk_nxt = r_tk + TK_W'(1);
                    end
                end
                w_tick_nxt = (w_cnt_nxt == w_div_m1) && (w_state_nxt != S_IDLE);
                // Strobe is issued with the closing tick that opens a payload slot
                w_bit_rd_nxt = w_in_slot && w_tick_nxt && (r_tk == w_tpb_m1) &&
                               (w_adv_state == S_DATA);
            end
        endcase
        if (w_abort) begin
            w_cnt_nxt    = '0;
            w_tk_nxt     = '0;
            w_idx_nxt    = '0;
            w_busy_nxt   = 1'b0;
            w_en_nxt     = 1'b0;
            w_data_nxt   = 1'b0;
            w_viol_nxt   = 1'b0;
            w_mblf_nxt   = 1'b0;
            w_bit_rd_nxt = 1'b0;
            w_tick_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
            w_clear_nxt  = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_tk     <= '0;
            r_idx    <= '0;
            r_m      <= '0;
            r_trext  <= 1'b0;
            r_div    <= '0;
            r_len    <= '0;
            r_bit_rd <= 1'b0;
            r_tick   <= 1'b0;
            r_en     <= 1'b0;
            r_data   <= 1'b0;
            r_viol   <= 1'b0;
            r_mblf   <= 1'b0;
            r_clear  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_tk     <= w_tk_nxt;
            r_idx    <= w_idx_nxt;
            r_m      <= w_m_nxt;
            r_trext  <= w_trext_nxt;
            r_div    <= w_div_nxt;
            r_len    <= w_len_nxt;
            r_bit_rd <= w_bit_rd_nxt;
            r_tick   <= w_tick_nxt;
            r_en     <= w_en_nxt;
            r_data   <= w_data_nxt;
            r_viol   <= w_viol_nxt;
            r_mblf   <= w_mblf_nxt;
            r_clear  <= w_clear_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.o_bit_rd      = r_bit_rd;
    assign bus.o_en2blf_mod  = r_tick;
    assign bus.o_enable_mod  = r_en;
    assign bus.o_data_ocu    = r_data;
    assign bus.o_violate_mod = r_viol;
    assign bus.o_mblf_mod    = r_mblf;
    assign bus.o_clear_cu    = r_clear;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
endmodule

// File: tb/tb_bs_tx_sequencer.sv
// Testbench for bs_tx_sequencer: per-cycle comparison against a slot-list
// reference model, table of reply configurations with hand-derived tick
// counts, hand sequences for abort/restart/reset, and random replies.
module tb_bs_tx_sequencer;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned DIV_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bs_tx_sequencer_if #(.LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();
    bs_tx_sequencer #(.LEN_W(LEN_W), .DIV_W(DIV_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic bit_rd, tick, en, data, viol, mblf, clear, busy, done;
    } outs_t;

    typedef struct {
        int m; int trext; int div; int len; logic [15:0] bits;
        int en_t; int strobes; int viol_t; int mblf_t;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: list of slots of the reply
    bit m_data[$];
    bit m_viol[$];
    bit m_mblf[$];
    int m_pay[$];

    int st_en, st_strobe, st_viol, st_mblf, st_tail, st_done, st_clear;

    initial begin
        #50_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t sample();
        outs_t o;
        o = {bus.o_bit_rd, bus.o_en2blf_mod, bus.o_enable_mod, bus.o_data_ocu, bus.o_violate_mod,
             bus.o_mblf_mod, bus.o_clear_cu, bus.o_busy, bus.o_done};
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (bit_rd,tick,en,data,viol,mblf,clear,busy,done)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void push_slot(bit d, bit v, bit mb, int p);
        m_data.push_back(d);
        m_viol.push_back(v);
        m_mblf.push_back(mb);
        m_pay.push_back(p);
    endfunction

    function automatic void build_model(int m, int trext, int len, logic [15:0] bits);
        int fm0_pat[6] = '{1, 0, 1, 0, 0, 1};
        int mil_pat[6] = '{0, 1, 0, 1, 1, 1};
        m_data.delete(); m_viol.delete(); m_mblf.delete(); m_pay.delete();
        if (m != 0)
            for (int i = 0; i < (trext != 0 ? 16 : 4); i++) push_slot(1'b0, 1'b0, 1'b1, -1);
        if (m == 0 && trext != 0)
            for (int i = 0; i < 12; i++) push_slot(1'b0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            if (m == 0) push_slot(fm0_pat[i] != 0, i == 4, 1'b0, -1);
            else        push_slot(mil_pat[i] != 0, 1'b0, 1'b0, -1);
        end
        for (int i = 0; i < len; i++) push_slot(bits[i], 1'b0, 1'b0, i);
        push_slot(1'b1, 1'b0, 1'b0, -1);
    endfunction

    // Expected outputs in cycle t after the start cycle (t = 0)
    function automatic outs_t expect_at(int t, int P, int div);
        outs_t e;
        int s, ns;
        e  = '0;
        ns = m_data.size();
        if (t >= 1 && t <= ns * P) begin
            s = (t - 1) / P;
            e.en = 1'b1; e.busy = 1'b1;
            e.data = m_data[s]; e.viol = m_viol[s]; e.mblf = m_mblf[s];
            e.tick = (t % div == 0);
            e.bit_rd = (t % P == 0) && (s + 1 < ns) && (m_pay[s + 1] >= 0);
        end else if (t > ns * P && t <= ns * P + 2 * div) begin
            e.busy = 1'b1; e.data = 1'b1; e.tick = (t % div == 0);
        end else if (t == ns * P + 2 * div + 1) begin
            e.busy = 1'b1; e.data = 1'b1; e.done = 1'b1; e.clear = 1'b1;
        end
        return e;
    endfunction

    // Runs one reply from the current cycle; optional abort after N strobes,
    // optional second start pulse at cycle restart_t while busy.
    task automatic run_reply(input int m, input int trext, input int div_raw, input int len,
                             input logic [15:0] bits, input int abort_after, input int restart_t);
        int div, P, t_end, abort_t, nstrobe;
        outs_t act, exp;
        div = (div_raw < 2) ? 2 : div_raw;
        P   = div * (2 << m);
        build_model(m, trext, len, bits);
        t_end   = m_data.size() * P + 2 * div + 2;
        abort_t = 0;
        nstrobe = 0;
        st_en = 0; st_strobe = 0; st_viol = 0; st_mblf = 0; st_tail = 0; st_done = 0; st_clear = 0;
        bus.i_start   = 1'b1;
        bus.i_abort   = 1'b0;
        bus.i_m_dec   = 2'(m);
        bus.i_trext   = 1'(trext);
        bus.i_blf_div = DIV_W'(div_raw);
        bus.i_tx_len  = LEN_W'(len);
        bus.i_tx_bit  = 1'($urandom);
        for (int t = 1; t <= t_end; t++) begin
            step();
            act = sample();
            if (abort_t != 0 && t > abort_t) begin
                exp = '0;
                exp.clear = (t == abort_t + 1);
            end else begin
                exp = expect_at(t, P, div);
            end
            check_outs($sformatf("m%0d trext%0d div%0d len%0d cycle %0d", m, trext, div_raw, len, t),
                       act, exp);
            st_en     += int'(act.tick && act.en);
            st_strobe += int'(act.bit_rd);
            st_viol   += int'(act.tick && act.viol);
            st_mblf   += int'(act.tick && act.mblf);
            st_tail   += int'(act.tick && act.busy && !act.en);
            st_done   += int'(act.done);
            st_clear  += int'(act.clear);
            if (exp.bit_rd) begin
                nstrobe++;
                if (abort_after > 0 && nstrobe == abort_after && abort_t == 0) abort_t = t + 1;
            end
            if (abort_t != 0 && t >= abort_t + 4) break;
            // Drive cycle t; config changes after start must be ignored
            bus.i_start   = (t == restart_t);
            bus.i_abort   = (t == abort_t);
            bus.i_m_dec   = 2'($urandom);
            bus.i_trext   = 1'($urandom);
            bus.i_blf_div = DIV_W'($urandom);
            bus.i_tx_len  = LEN_W'($urandom);
            if (exp.bit_rd) bus.i_tx_bit = bits[m_pay[(t - 1) / P + 1]];
            else            bus.i_tx_bit = 1'($urandom);
        end
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 0, 4, 4, 16'h000D,  22, 4, 2,   0};
        tbl[1] = '{1, 1, 2, 2, 16'h0002, 100, 2, 0,  64};
        tbl[2] = '{0, 1, 1, 0, 16'h0000,  38, 0, 2,   0};
        tbl[3] = '{3, 0, 3, 3, 16'h0003, 224, 3, 0,  64};
        tbl[4] = '{2, 1, 2, 1, 16'h0001, 192, 1, 0, 128};
        tbl[5] = '{0, 0, 0, 1, 16'h0000,  16, 1, 2,   0};

        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_m_dec = 2'b00; bus.i_trext = 1'b0;
        bus.i_blf_div = '0; bus.i_tx_len = '0; bus.i_tx_bit = 1'b0;
        step();
        check_outs("reset state", sample(), '0);
        step();
        rst_n = 1'b1;
        step();
        check_outs("idle after reset", sample(), '0);

        // Reply configurations with hand-derived tick counts
        for (int i = 0; i < 6; i++) begin
            run_reply(tbl[i].m, tbl[i].trext, tbl[i].div, tbl[i].len, tbl[i].bits, 0, 0);
            check_int($sformatf("vec%0d enable ticks", i), st_en, tbl[i].en_t);
            check_int($sformatf("vec%0d strobes", i), st_strobe, tbl[i].strobes);
            check_int($sformatf("vec%0d violate ticks", i), st_viol, tbl[i].viol_t);
            check_int($sformatf("vec%0d mblf ticks", i), st_mblf, tbl[i].mblf_t);
            check_int($sformatf("vec%0d tail ticks", i), st_tail, 2);
            check_int($sformatf("vec%0d done pulses", i), st_done, 1);
            check_int($sformatf("vec%0d clear pulses", i), st_clear, 1);
        end

        // Abort mid-DATA after the third strobe
        run_reply(2, 0, 2, 8, 16'h00A5, 3, 0);
        check_int("abort strobes", st_strobe, 3);
        check_int("abort done pulses", st_done, 0);
        check_int("abort clear pulses", st_clear, 1);

        // Second start during a busy M8 reply, then a fresh reply
        run_reply(3, 0, 2, 2, 16'h0001, 0, 40);
        check_int("restart enable ticks", st_en, 208);
        check_int("restart done pulses", st_done, 1);
        run_reply(3, 0, 3, 1, 16'h0001, 0, 0);
        check_int("fresh reply done pulses", st_done, 1);

        // Abort in IDLE is ignored; abort beats start
        bus.i_abort = 1'b1;
        step();
        check_outs("idle abort ignored", sample(), '0);
        bus.i_start = 1'b1;
        step();
        check_outs("abort beats start", sample(), '0);
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        step();
        check_outs("still idle", sample(), '0);

        // Reset in the middle of the preamble
        bus.i_m_dec = 2'b00; bus.i_trext = 1'b0; bus.i_blf_div = DIV_W'(2); bus.i_tx_len = LEN_W'(2);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        repeat (9) step();
        check_int("busy before reset", int'(bus.o_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async reset mid-preamble", sample(), '0);
        step();
        rst_n = 1'b1;
        step();
        check_outs("idle after reset release", sample(), '0);
        run_reply(0, 0, 2, 2, 16'h0002, 0, 0);
        check_int("post-reset done pulses", st_done, 1);

        // Random replies
        for (int r = 0; r < 8; r++) begin
            int m, trext, div, len, ab, rs;
            logic [15:0] bits;
            m     = int'($urandom_range(0, 3));
            trext = int'($urandom_range(0, 1));
            div   = int'($urandom_range(0, 5));
            len   = int'($urandom_range(0, 6));
            bits  = 16'($urandom);
            rs    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            ab    = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            run_reply(m, trext, div, len, bits, ab, rs);
            check_int($sformatf("rand%0d done pulses", r), st_done, (ab > 0) ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
